// File: rtl/spi_flash_read_if.sv
// Byte-stream link between spi_flash_read (slave modport) and a byte-wide SPI master (master modport).
interface spi_flash_read_if;
  // Handshake: a tx byte transfers on every clock edge where tx_empty is low (valid) and
  // tx_get is high (ready); tx_get with tx_empty high moves nothing. An rx byte transfers
  // on every edge where rx_put is high; the receiver never back-pressures.
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_get;
  logic [7:0] rx_data;
  logic       rx_put;

  modport slave  (output tx_data, tx_empty, input  tx_get, rx_data, rx_put);
  modport master (input  tx_data, tx_empty, output tx_get, rx_data, rx_put);
endinterface

// File: rtl/spi_flash_read.sv
// Flash read sequencer: sends command + 24-bit address (+ dummy with SPI_FLASH_FAST_READ_EN),
// clocks out count 0xFF fill bytes and returns the bytes received for them on data/valid.
module spi_flash_read #(
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [23:0]     addr,
  input  logic [CW-1:0]   count,
  output logic            busy,
  output logic            done,
  output logic [7:0]      data,
  output logic            valid,
  output logic [2:0]      dbg_state,
  spi_flash_read_if.slave spi
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         H   = 5;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         H   = 4;
`endif
  localparam logic [CW:0] HLEN = (CW+1)'(H);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [23:0]   addr_q;
  logic [CW-1:0] cnt_q;
  logic [CW:0]   tx_cnt, rx_cnt, total;
  logic          accept, tx_take, rx_take;

  // One extra counter bit so header plus a maximal payload never wraps.
  assign total   = {1'b0, cnt_q} + HLEN;
  assign accept  = (state == S_IDLE) && start && (count != '0);
  assign tx_take = spi.tx_get && !spi.tx_empty;
  assign rx_take = spi.rx_put && busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = (count != '0) ? S_HDR : S_DONE;
      S_HDR:   if (tx_take && (tx_cnt == HLEN - 1'b1)) state_n = S_FILL;
      S_FILL:  if (tx_take && (tx_cnt == total - 1'b1)) state_n = S_DRAIN;
      S_DRAIN: if (rx_cnt >= total) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    spi.tx_empty = 1'b1;
    spi.tx_data  = 8'h00;
    dbg_state    = state;
    unique case (state)
      S_HDR: begin
        busy         = 1'b1;
        spi.tx_empty = 1'b0;
        // Index 4 (fast-read dummy) falls to the 0x00 default.
        case (tx_cnt[2:0])
          3'd0:    spi.tx_data = CMD;
          3'd1:    spi.tx_data = addr_q[23:16];
          3'd2:    spi.tx_data = addr_q[15:8];
          3'd3:    spi.tx_data = addr_q[7:0];
          default: spi.tx_data = 8'h00;
        endcase
      end
      S_FILL: begin
        busy         = 1'b1;
        spi.tx_empty = 1'b0;
        spi.tx_data  = 8'hFF;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      data   <= 8'h00;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        addr_q <= addr;
        cnt_q  <= count;
        tx_cnt <= '0;
        rx_cnt <= '0;
      end else begin
        if (tx_take) tx_cnt <= tx_cnt + 1'b1;
        // Bytes echoed during the header are discarded; the rest are payload.
        if (rx_take && (rx_cnt < total)) begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt >= HLEN) begin
            data  <= spi.rx_data;
            valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/spi_flash_read.md
SPI_FLASH_READ -- requirements
Module: spi_flash_read

Interface
REQ-001 Parameter: CW, 16, width of byte-count input (read length 0 .. 2^CW-1).
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a read transaction.
REQ-005 addr  input  24  flash byte address, sampled on accepted start.
REQ-006 count  input  CW  number of data bytes to read, sampled on accepted start.
REQ-007 busy  output  1  high from accepted start until done.
REQ-008 done  output  1  one-cycle pulse at transaction end.
REQ-009 data  output  8  received flash data byte.
REQ-010 valid  output  1  one-cycle strobe, data holds a payload byte.
REQ-011 tx_data  output  8  byte offered to the SPI master source port.
REQ-012 tx_get  input  1  SPI master consumes tx_data this cycle.
REQ-013 tx_empty  output  1  high when no byte is offered; the master ends the frame (raises CS) on empty.
REQ-014 rx_data  input  8  byte shifted in by the SPI master.
REQ-015 rx_put  input  1  rx_data is valid this cycle.

Function
REQ-016 States: IDLE, HDR (header bytes), FILL (fill bytes for payload), DRAIN (await remaining rx), DONE.
REQ-017 IDLE: start with count!=0 latches addr/count, sets busy, enters HDR next cycle; start with count==0 sets no busy, pulses done next cycle, no bytes offered.
REQ-018 start while busy is ignored; latched addr/count unaffected.
REQ-019 Header order: command, addr[23:16], addr[15:8], addr[7:0] (plus dummy, see Configuration); header length H.
REQ-020 tx_data selected from tx byte index; index advances only on tx_get while tx_empty=0; new byte shown the cycle after tx_get.
REQ-021 tx_empty=0 in HDR and FILL; tx_empty=1 in IDLE, DRAIN, DONE.
REQ-022 HDR -> FILL after H-th tx_get; FILL offers 0xFF, FILL -> DRAIN after count-th fill tx_get.
REQ-023 tx_get while tx_empty=1 is ignored.
REQ-024 rx counter counts every rx_put while busy; first H bytes discarded, bytes H..H+count-1 copied to data with valid=1 same cycle as... registered, one cycle after rx_put.
REQ-025 rx_put while not busy is ignored; valid stays low.
REQ-026 DRAIN -> DONE when rx counter reaches H+count, including an rx_put coinciding with the last tx_get (state goes straight to DONE via DRAIN the cycle after).
REQ-027 DONE: done=1 one cycle, busy cleared same cycle, return to IDLE; start in DONE cycle ignored.
REQ-028 Counters: tx/rx counters CW+1 bits wide; count=2^CW-1 must not wrap.

Reset
REQ-029 On reset: state IDLE, busy=0, done=0, valid=0, data=0x00, tx_empty=1, tx_data=0x00, counters zero.
REQ-030 Reset mid-transaction aborts immediately; no done pulse; tx_empty=1 during and after reset.

Configuration
REQ-031 Macro SPI_FLASH_FAST_READ_EN: defined -> command 0x0B followed by one 0x00 dummy byte after address, H=5; undefined -> command 0x03, no dummy, H=4.

Verification
REQ-032 Bench: spi_master instance, MISO looped to MOSI, strobe step; loopback returns transmitted bytes.
REQ-033 start, addr=0x123456, count=3, macro off -> MOSI bytes 03 12 34 56 FF FF FF, valid thrice with data FF, then done, busy low.
REQ-034 Same with SPI_FLASH_FAST_READ_EN -> MOSI 0B 12 34 56 00 FF FF FF, three valid strobes, done.
REQ-035 start with count=0 -> done one cycle later, busy never high, tx_empty held 1, no valid.
REQ-036 Second start pulse mid-transfer with addr=0xABCDEF -> ignored; header bytes and valid count match first request only.
REQ-037 reset asserted after 2nd header byte -> busy=0, tx_empty=1, no done; fresh start afterwards completes normally.
